cmac_tap_sequencer: RTL

Sequencer for one shared pipelined complex multiplier (sample-pair × coefficient → I/Q partial products) in the FIR datapath. Per output sample it walks the multiplier through all TAPS coefficient/sample-pair addresses, one per cycle. It tracks the multiplier's fixed latency and accumulates the returned I/Q partial products. The finished complex result goes out on a valid/ready port.

---
 rtl/cmac_tap_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cmac_tap_sequencer.sv
// Tap sequencer for one shared pipelined complex multiplier: issues every tap address
// once per output sample, accumulates the returned I/Q products and presents the result.
module cmac_tap_sequencer #(
    parameter int unsigned TAPS     = 16,
    parameter int unsigned SW       = 25,
    parameter int unsigned CW       = 27,
    parameter int unsigned MULT_LAT = 1,
    parameter int unsigned PW       = SW + CW + 1,
    parameter int unsigned AW       = $clog2(TAPS),
    parameter int unsigned ACC_W    = PW + $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             flush,
    output logic [AW-1:0]    tap_addr,
    output logic             mult_issue,
    input  logic [PW-1:0]    pp_i,
    input  logic [PW-1:0]    pp_q,
    output logic [ACC_W-1:0] y_i,
    output logic [ACC_W-1:0] y_q,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             busy
);

    localparam int unsigned DW = $clog2(MULT_LAT + 1);
    localparam int unsigned EW = ACC_W - PW;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StOut   = 2'd3;

    localparam logic [AW-1:0] LastTap = AW'(TAPS - 1);

    logic [1:0]          stateQ, stateD;
    logic [AW-1:0]       tapCntQ, tapCntD;
    logic [DW-1:0]       drainCntQ, drainCntD;
    logic [MULT_LAT-1:0] pipeQ, pipeD;
    logic [ACC_W-1:0]    iAccQ, iAccD;
    logic [ACC_W-1:0]    qAccQ, qAccD;
    logic                clearAcc;
    logic                ppLand;

    assign start_ready = (stateQ == StIdle);
    assign busy        = (stateQ != StIdle);
    assign mult_issue  = (stateQ == StIssue);
    assign y_valid     = (stateQ == StOut);
    assign tap_addr    = mult_issue ? tapCntQ : '0;
    assign y_i         = iAccQ;
    assign y_q         = qAccQ;
    assign ppLand      = pipeQ[MULT_LAT-1];

    always_comb begin
        stateD    = stateQ;
        tapCntD   = tapCntQ;
        drainCntD = drainCntQ;
        clearAcc  = 1'b0;
        case (stateQ)
            StIdle: begin
                if (start_valid) begin
                    clearAcc = 1'b1;
                    tapCntD  = '0;
                    stateD   = StIssue;
                end
            end
            StIssue: begin
                if (tapCntQ == LastTap) begin
                    tapCntD   = '0;
                    drainCntD = DW'(MULT_LAT);
                    stateD    = StDrain;
                end else begin
                    tapCntD = tapCntQ + AW'(1);
                end
            end
            StDrain: begin
                drainCntD = drainCntQ - DW'(1);
                if (drainCntQ == DW'(1)) begin
                    stateD = StOut;
                end
            end
            StOut: begin
                if (y_ready) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
        // Abort wins over any handshake; accumulator contents are simply abandoned.
        if (flush) begin
            stateD    = StIdle;
            tapCntD   = '0;
            drainCntD = '0;
            clearAcc  = 1'b0;
        end
    end

    always_comb begin
        pipeD = '0;
        if (!flush) begin
            pipeD[0] = mult_issue;
            for (int i = 1; i < int'(MULT_LAT); i++) begin
                pipeD[i] = pipeQ[i-1];
            end
        end
    end

    always_comb begin
        iAccD = iAccQ;
        qAccD = qAccQ;
        if (clearAcc) begin
            iAccD = '0;
            qAccD = '0;
        end else if (ppLand && !flush) begin
            iAccD = iAccQ + {{EW{pp_i[PW-1]}}, pp_i};
            qAccD = qAccQ + {{EW{pp_q[PW-1]}}, pp_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= StIdle;
            tapCntQ   <= '0;
            drainCntQ <= '0;
            pipeQ     <= '0;
            iAccQ     <= '0;
            qAccQ     <= '0;
        end else begin
            stateQ    <= stateD;
            tapCntQ   <= tapCntD;
            drainCntQ <= drainCntD;
            pipeQ     <= pipeD;
            iAccQ     <= iAccD;
            qAccQ     <= qAccD;
        end
    end

endmodule
